// File: rtl/ddr_app_pkg.sv
// Shared types and constants for the MIG native app-interface responder model.
// 4:1 mode, BL8, 32-bit DDR3: one 256-bit UI word per command.
package ddr_app_pkg;

  localparam int APP_ADDR_W = 27;
  localparam int APP_DATA_W = 256;
  localparam int APP_MASK_W = 32;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  typedef struct packed {
    logic [2:0]            cmd;
    logic [APP_ADDR_W-1:0] addr;
  } cmd_entry_t;

  function automatic logic cmd_supported(input logic [2:0] cmd);
    return (cmd == CMD_WRITE) || (cmd == CMD_READ);
  endfunction

endpackage

// File: rtl/ddr_app_sfifo.sv
// Synchronous first-word-fall-through FIFO with full/empty flags.
// DEPTH must be a power of two and at least 2.
module ddr_app_sfifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [CNT_W-1:0] wr_ptr_reg;
  logic [CNT_W-1:0] rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                 (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
  assign dout  = mem_reg[rd_ptr_reg[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + CNT_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_reg[wr_ptr_reg[PTR_W-1:0]] <= din;
  end

endmodule

// File: rtl/ddr_app_resp_model.sv
// Behavioural-but-synthesizable stand-in for the MIG 7-series native app port:
// calibration delay, app_rdy backpressure, in-order execution, fixed read latency.
module ddr_app_resp_model
  import ddr_app_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int INIT_CYCLES  = 64,
  parameter int RD_LAT       = 6,
  parameter int CMD_DEPTH    = 4,
  parameter int WDF_DEPTH    = 4,
  parameter int STALL_PERIOD = 0
) (
  input  logic                  i_ddr3_clk,
  input  logic                  i_rst_n,
  output logic                  o_init_calib_complete,
  input  logic [APP_ADDR_W-1:0] i_app_addr,
  input  logic [2:0]            i_app_cmd,
  input  logic                  i_app_en,
  output logic                  o_app_rdy,
  input  logic [APP_DATA_W-1:0] i_app_wdf_data,
  input  logic [APP_MASK_W-1:0] i_app_wdf_mask,
  input  logic                  i_app_wdf_wren,
  input  logic                  i_app_wdf_end,
  output logic                  o_app_wdf_rdy,
  output logic [APP_DATA_W-1:0] o_app_rd_data,
  output logic                  o_app_rd_data_valid,
  output logic                  o_app_rd_data_end,
  output logic                  o_err_cmd,
  output logic                  o_err_wdf
);

  localparam int DEPTH   = 1 << ADDR_W;
  localparam int INIT_W  = $clog2(INIT_CYCLES + 1);
  localparam int CMD_W   = $bits(cmd_entry_t);
  localparam int WDF_W   = APP_DATA_W + APP_MASK_W;
  localparam int STALL_W = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;

  logic [INIT_W-1:0]     init_cnt_reg;
  logic                  init_reg;
  logic                  stall;
  logic                  err_cmd_reg;
  logic                  err_wdf_reg;

  cmd_entry_t            cmd_in;
  cmd_entry_t            cmd_head;
  logic [CMD_W-1:0]      cmd_dout;
  logic                  cmd_accept;
  logic                  cmd_push;
  logic                  cmd_pop;
  logic                  cmd_full;
  logic                  cmd_empty;

  logic [WDF_W-1:0]      wdf_dout;
  logic [APP_DATA_W-1:0] wdf_data;
  logic [APP_MASK_W-1:0] wdf_mask;
  logic                  wdf_push;
  logic                  wdf_full;
  logic                  wdf_empty;

  logic                  head_valid;
  logic                  exec_write;
  logic                  exec_read;
  logic [ADDR_W-1:0]     word_idx;
  logic [APP_MASK_W-1:0] byte_we;
  logic                  unused_addr_bits;

  logic [APP_DATA_W-1:0] mem_reg [DEPTH];
  logic [APP_DATA_W-1:0] rd_pipe_reg [RD_LAT];
  logic [RD_LAT-1:0]     rd_vld_reg;

  // Calibration model: count up once, then latch done.
  always_ff @(posedge i_ddr3_clk) begin
    if (!i_rst_n) begin
      init_cnt_reg <= '0;
      init_reg     <= 1'b0;
    end else if (!init_reg) begin
      init_cnt_reg <= init_cnt_reg + INIT_W'(1);
      if (init_cnt_reg == INIT_W'(INIT_CYCLES - 1)) init_reg <= 1'b1;
    end
  end

  generate
    if (STALL_PERIOD > 0) begin : g_stall
      logic [STALL_W-1:0] stall_cnt_reg;
      always_ff @(posedge i_ddr3_clk) begin
        if (!i_rst_n || stall_cnt_reg == STALL_W'(STALL_PERIOD - 1))
          stall_cnt_reg <= '0;
        else
          stall_cnt_reg <= stall_cnt_reg + STALL_W'(1);
      end
      assign stall = (stall_cnt_reg == STALL_W'(STALL_PERIOD - 1));
    end else begin : g_no_stall
      assign stall = 1'b0;
    end
  endgenerate

  assign o_app_rdy     = init_reg & ~cmd_full & ~stall;
  assign o_app_wdf_rdy = init_reg & ~wdf_full;

  // Unsupported commands are accepted (handshake completes) but never queued.
  assign cmd_accept  = i_app_en & o_app_rdy;
  assign cmd_push    = cmd_accept & cmd_supported(i_app_cmd);
  assign cmd_in.cmd  = i_app_cmd;
  assign cmd_in.addr = i_app_addr;
  assign wdf_push    = i_app_wdf_wren & o_app_wdf_rdy;

  ddr_app_sfifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk   (i_ddr3_clk),
    .rst_n (i_rst_n),
    .push  (cmd_push),
    .din   (cmd_in),
    .pop   (cmd_pop),
    .dout  (cmd_dout),
    .full  (cmd_full),
    .empty (cmd_empty)
  );

  ddr_app_sfifo #(.WIDTH(WDF_W), .DEPTH(WDF_DEPTH)) u_wdf_fifo (
    .clk   (i_ddr3_clk),
    .rst_n (i_rst_n),
    .push  (wdf_push),
    .din   ({i_app_wdf_data, i_app_wdf_mask}),
    .pop   (exec_write),
    .dout  (wdf_dout),
    .full  (wdf_full),
    .empty (wdf_empty)
  );

  assign cmd_head = cmd_entry_t'(cmd_dout);
  assign wdf_data = wdf_dout[WDF_W-1:APP_MASK_W];
  assign wdf_mask = wdf_dout[APP_MASK_W-1:0];

  // A write head with no data blocks everything behind it, keeping strict order.
  assign head_valid = i_rst_n & ~cmd_empty;
  assign exec_write = head_valid & (cmd_head.cmd == CMD_WRITE) & ~wdf_empty;
  assign exec_read  = head_valid & (cmd_head.cmd == CMD_READ);
  assign cmd_pop    = exec_write | exec_read;
  assign word_idx   = cmd_head.addr[ADDR_W+2:3];

  assign unused_addr_bits = ^{cmd_head.addr[2:0], cmd_head.addr[APP_ADDR_W-1:ADDR_W+3]};

  genvar gi;
  generate
    for (gi = 0; gi < APP_MASK_W; gi++) begin : g_byte_we
      assign byte_we[gi] = exec_write & ~wdf_mask[gi];
    end
  endgenerate

  // Array is deliberately not reset so contents survive a reset pulse.
  always_ff @(posedge i_ddr3_clk) begin
    for (int b = 0; b < APP_MASK_W; b++) begin
      if (byte_we[b]) mem_reg[word_idx][b*8 +: 8] <= wdf_data[b*8 +: 8];
    end
    if (exec_read) rd_pipe_reg[0] <= mem_reg[word_idx];
    for (int i = 1; i < RD_LAT; i++) rd_pipe_reg[i] <= rd_pipe_reg[i-1];
  end

  always_ff @(posedge i_ddr3_clk) begin
    if (!i_rst_n) begin
      rd_vld_reg  <= '0;
      err_cmd_reg <= 1'b0;
      err_wdf_reg <= 1'b0;
    end else begin
      rd_vld_reg <= (rd_vld_reg << 1) | RD_LAT'(exec_read);
      if (cmd_accept && !cmd_supported(i_app_cmd)) err_cmd_reg <= 1'b1;
      if (i_app_wdf_wren && !i_app_wdf_end)        err_wdf_reg <= 1'b1;
    end
  end

  assign o_init_calib_complete = init_reg;
  assign o_app_rd_data_valid   = rd_vld_reg[RD_LAT-1];
  assign o_app_rd_data_end     = rd_vld_reg[RD_LAT-1];
  assign o_app_rd_data         = rd_vld_reg[RD_LAT-1] ? rd_pipe_reg[RD_LAT-1] : '0;
  assign o_err_cmd             = err_cmd_reg;
  assign o_err_wdf             = err_wdf_reg;

endmodule
